mem_bus_responder: RTL and testbench

//  Target side of the byte-wide CPU memory bus (mem_a/mem_wr/mem_dout/mem_din/io_buffer_full).

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_responder_io_tx_fifo.sv | 70 +++++++
 rtl/mem_bus_responder.sv | 121 ++++++++++++
 tb/tb_mem_bus_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared bus constants and transaction decode for the CPU memory bus responder.
package mem_bus_pkg;

    localparam int BUS_DW = 8;
    localparam int BUS_AW = 32;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_OFS_DATA = 3'h0;
    localparam logic [2:0] IO_OFS_STAT = 3'h4;

    typedef enum logic [1:0] {
        TXN_RAM_RD = 2'd0,
        TXN_RAM_WR = 2'd1,
        TXN_IO_RD  = 2'd2,
        TXN_IO_WR  = 2'd3
    } txn_kind_e;

    // Every bus cycle is exactly one of these four transaction kinds
    function automatic txn_kind_e decode_txn(input logic [17:16] sel, input logic wr);
        txn_kind_e kind;
        if (sel == IO_SEL) begin
            kind = wr ? TXN_IO_WR : TXN_IO_RD;
        end else begin
            kind = wr ? TXN_RAM_WR : TXN_RAM_RD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_bus_responder_io_tx_fifo.sv
// Synchronous TX FIFO with registered count/full/empty; head is read straight from storage.
module io_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_nxt;

    // Push decision uses the pre-edge full flag, so a pop cannot make room for it
    assign w_push_ok = i_push & ~r_full;
    assign w_pop_ok  = i_pop & ~r_empty;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write port
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, count and the flags registered alongside the count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == CNT_W'(0));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the byte-wide CPU memory bus: RAM, IO window decode, UART TX FIFO/RX register, halt flag.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int    ADDR_W     = 17,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [BUS_AW-1:0] mem_a,
    input  logic              mem_wr,
    input  logic [BUS_DW-1:0] mem_dout,
    output logic [BUS_DW-1:0] mem_din,
    output logic              io_buffer_full,
    output logic [BUS_DW-1:0] uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [BUS_DW-1:0] uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              halt_out
);
    logic [BUS_DW-1:0] r_ram [0:(2**ADDR_W)-1];
    logic [BUS_DW-1:0] r_din;
    logic [BUS_DW-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_halt;

    txn_kind_e         w_kind;
    logic [ADDR_W-1:0] w_ram_idx;
    logic [2:0]        w_ofs;
    logic [BUS_DW-1:0] w_io_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_unused_addr;

    assign w_kind        = decode_txn(mem_a[17:16], mem_wr);
    assign w_ram_idx     = mem_a[ADDR_W-1:0];
    assign w_ofs         = mem_a[2:0];
    assign w_unused_addr = ^mem_a[BUS_AW-1:18];

    assign w_push = rdy_in & (w_kind == TXN_IO_WR) & (w_ofs == IO_OFS_DATA);
    assign w_pop  = rdy_in & uart_tx_ready;

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUS_DW)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (mem_dout),
        .o_head  (uart_tx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // IO read mux; unmapped offsets read as zero
    always_comb begin
        w_io_rdata = 8'h00;
        case (w_ofs)
            IO_OFS_DATA: w_io_rdata = r_rx_valid ? r_rx_data : 8'h00;
            IO_OFS_STAT: w_io_rdata = {6'b000000, r_rx_valid, w_full};
            default:     w_io_rdata = 8'h00;
        endcase
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (rdy_in && (w_kind == TXN_RAM_WR)) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    // Read data register: only read transactions update it
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_din <= 8'h00;
        end else if (rdy_in) begin
            case (w_kind)
                TXN_RAM_RD: r_din <= r_ram[w_ram_idx];
                TXN_IO_RD:  r_din <= w_io_rdata;
                default:    r_din <= r_din;
            endcase
        end
    end

    // RX holding register: a new strobe wins over a same-edge data read
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (rdy_in) begin
            if (uart_rx_valid) begin
                r_rx_data  <= uart_rx_data;
                r_rx_valid <= 1'b1;
            end else if ((w_kind == TXN_IO_RD) && (w_ofs == IO_OFS_DATA)) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // Sticky halt request
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_halt <= 1'b0;
        end else if (rdy_in && (w_kind == TXN_IO_WR) && (w_ofs == IO_OFS_STAT)) begin
            r_halt <= 1'b1;
        end
    end

    assign mem_din        = r_din;
    assign io_buffer_full = w_full;
    assign uart_tx_valid  = ~w_empty;
    assign halt_out       = r_halt;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed, table-driven bench for mem_bus_responder (FIFO_DEPTH=4).
module tb_mem_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        halt_out;

    int checks   = 0;
    int failures = 0;

    mem_bus_responder #(
        .ADDR_W     (17),
        .FIFO_DEPTH (4),
        .INIT_FILE  ("")
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_valid  (uart_rx_valid),
        .halt_out       (halt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        txr;
        logic [7:0]  rxd;
        logic        rxv;
        logic [7:0]  e_din;
        logic        e_full;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_halt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rdy, input logic [31:0] a, input logic wr,
                                input logic [7:0] dout, input logic txr, input logic [7:0] rxd,
                                input logic rxv, input logic [7:0] e_din, input logic e_full,
                                input logic e_txv, input logic [7:0] e_txd, input logic e_halt);
        vec_t v;
        v.rdy = rdy; v.a = a; v.wr = wr; v.dout = dout; v.txr = txr; v.rxd = rxd; v.rxv = rxv;
        v.e_din = e_din; v.e_full = e_full; v.e_txv = e_txv; v.e_txd = e_txd; v.e_halt = e_halt;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%02h expected=%02h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; mem_a = 32'h0003_0001; mem_wr = 1'b0; mem_dout = 8'h00;
        uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
    endtask

    task automatic run_rows(input int base);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk_in);
            rdy_in = vq[i].rdy; mem_a = vq[i].a; mem_wr = vq[i].wr; mem_dout = vq[i].dout;
            uart_tx_ready = vq[i].txr; uart_rx_data = vq[i].rxd; uart_rx_valid = vq[i].rxv;
            @(posedge clk_in);
            #1;
            chk("din",   base + i, mem_din,               vq[i].e_din);
            chk("full",  base + i, {7'd0, io_buffer_full}, {7'd0, vq[i].e_full});
            chk("txv",   base + i, {7'd0, uart_tx_valid},  {7'd0, vq[i].e_txv});
            chk("halt",  base + i, {7'd0, halt_out},       {7'd0, vq[i].e_halt});
            if (vq[i].e_txv) chk("txd", base + i, uart_tx_data, vq[i].e_txd);
        end
        vq.delete();
    endtask

    task automatic chk_reset_state(input int tag);
        chk("rst_din",  tag, mem_din,               8'h00);
        chk("rst_full", tag, {7'd0, io_buffer_full}, 8'h00);
        chk("rst_txv",  tag, {7'd0, uart_tx_valid},  8'h00);
        chk("rst_halt", tag, {7'd0, halt_out},       8'h00);
    endtask

    localparam logic [31:0] IOD = 32'h0003_0000;
    localparam logic [31:0] IOS = 32'h0003_0004;
    localparam logic [31:0] IOX = 32'h0003_0001;

    initial begin
        rst_in = 1'b0;
        drive_idle();
        #12;
        chk_reset_state(0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Build traffic: RAM byte in mem_din, three TX entries, halt set
        add(1, 32'h10, 1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 32'h10, 0, 8'h00, 0, 0, 0, 8'h77, 0, 0, 8'h00, 0);
        add(1, IOD,    1, 8'hA1, 0, 0, 0, 8'h77, 0, 1, 8'hA1, 0);
        add(1, IOD,    1, 8'hA2, 0, 0, 0, 8'h77, 0, 1, 8'hA1, 0);
        add(1, IOD,    1, 8'hA3, 0, 0, 0, 8'h77, 0, 1, 8'hA1, 0);
        add(1, IOS,    1, 8'h00, 0, 0, 0, 8'h77, 0, 1, 8'hA1, 1);
        run_rows(100);

        // Asynchronous reset mid-cycle, checked before any clock edge
        @(negedge clk_in);
        drive_idle();
        #2 rst_in = 1'b0;
        #1 chk_reset_state(1);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Byte writes then 1-cycle-latency reads, plus read-after-write
        add(1, 32'h100, 1, 8'h11, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 32'h101, 1, 8'h22, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 32'h102, 1, 8'h33, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 32'h103, 1, 8'h44, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 32'h100, 0, 8'h00, 0, 0, 0, 8'h11, 0, 0, 8'h00, 0);
        add(1, 32'h101, 0, 8'h00, 0, 0, 0, 8'h22, 0, 0, 8'h00, 0);
        add(1, 32'h102, 0, 8'h00, 0, 0, 0, 8'h33, 0, 0, 8'h00, 0);
        add(1, 32'h103, 0, 8'h00, 0, 0, 0, 8'h44, 0, 0, 8'h00, 0);
        add(1, 32'h104, 1, 8'h55, 0, 0, 0, 8'h44, 0, 0, 8'h00, 0);
        add(1, 32'h104, 0, 8'h00, 0, 0, 0, 8'h55, 0, 0, 8'h00, 0);
        // Fill FIFO, drop 5th, status read, drain
        add(1, IOD, 1, 8'h01, 0, 0, 0, 8'h55, 0, 1, 8'h01, 0);
        add(1, IOD, 1, 8'h02, 0, 0, 0, 8'h55, 0, 1, 8'h01, 0);
        add(1, IOD, 1, 8'h03, 0, 0, 0, 8'h55, 0, 1, 8'h01, 0);
        add(1, IOD, 1, 8'h04, 0, 0, 0, 8'h55, 1, 1, 8'h01, 0);
        add(1, IOD, 1, 8'h05, 0, 0, 0, 8'h55, 1, 1, 8'h01, 0);
        add(1, IOS, 0, 8'h00, 0, 0, 0, 8'h01, 1, 1, 8'h01, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h02, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h03, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h04, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        // Push+pop on same edge at count 2, then drain to prove count stayed 2
        add(1, IOD, 1, 8'h61, 0, 0, 0, 8'h00, 0, 1, 8'h61, 0);
        add(1, IOD, 1, 8'h62, 0, 0, 0, 8'h00, 0, 1, 8'h61, 0);
        add(1, IOD, 1, 8'h63, 1, 0, 0, 8'h00, 0, 1, 8'h62, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h63, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        // Push to full FIFO with same-edge pop is still dropped
        add(1, IOD, 1, 8'h71, 0, 0, 0, 8'h00, 0, 1, 8'h71, 0);
        add(1, IOD, 1, 8'h72, 0, 0, 0, 8'h00, 0, 1, 8'h71, 0);
        add(1, IOD, 1, 8'h73, 0, 0, 0, 8'h00, 0, 1, 8'h71, 0);
        add(1, IOD, 1, 8'h74, 0, 0, 0, 8'h00, 1, 1, 8'h71, 0);
        add(1, IOD, 1, 8'h75, 1, 0, 0, 8'h00, 0, 1, 8'h72, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h73, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'h74, 0);
        add(1, IOX, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        // RX register: status, read, read-clears, same-edge strobe+read
        add(1, IOX, 0, 8'h00, 0, 8'h5A, 1, 8'h00, 0, 0, 8'h00, 0);
        add(1, IOS, 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 0, 8'h00, 0);
        add(1, IOD, 0, 8'h00, 0, 8'h00, 0, 8'h5A, 0, 0, 8'h00, 0);
        add(1, IOD, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, IOX, 0, 8'h00, 0, 8'hB1, 1, 8'h00, 0, 0, 8'h00, 0);
        add(1, IOD, 0, 8'h00, 0, 8'hC2, 1, 8'hB1, 0, 0, 8'h00, 0);
        add(1, IOS, 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 0, 8'h00, 0);
        add(1, IOD, 0, 8'h00, 0, 8'h00, 0, 8'hC2, 0, 0, 8'h00, 0);
        add(1, IOS, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        // rdy_in low: nothing moves, RX strobe lost; then halt
        add(1, 32'h200, 1, 8'h3C, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, IOD,     1, 8'h81, 0, 0, 0, 8'h00, 0, 1, 8'h81, 0);
        add(1, 32'h200, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 1, 8'h81, 0);
        add(0, 32'h200, 1, 8'hAA, 1, 8'h99, 1, 8'h3C, 0, 1, 8'h81, 0);
        add(0, IOS,     1, 8'h00, 1, 0, 0, 8'h3C, 0, 1, 8'h81, 0);
        add(0, IOX,     0, 8'h00, 1, 0, 0, 8'h3C, 0, 1, 8'h81, 0);
        add(1, IOS,     0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h81, 0);
        add(1, 32'h200, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 1, 8'h81, 0);
        add(1, IOS,     1, 8'h00, 0, 0, 0, 8'h3C, 0, 1, 8'h81, 1);
        add(1, 32'h104, 0, 8'h00, 0, 0, 0, 8'h55, 0, 1, 8'h81, 1);
        run_rows(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
